// File: rtl/lbox128_inv_iter.sv
// Iterative inverse Clyde-128 L-box over the 128-bit Spook state.
// One or two inverse-pair datapaths are shared across the two 64-bit (x,y) pairs.
module lbox128_inv_iter #(
    parameter int PAIRS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAIR0 = 2'd1,
        PAIR1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   in_reg;
    logic [127:0]   res_nxt;
    logic [63:0]    pair0_res;
    logic [63:0]    pair1_res;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] byte_bitrev(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*i+j] = w[8*i+7-j];
            end
        end
        return r;
    endfunction

    // Word-slot pair {hi, lo} <-> lane pair {x, y}; the mapping is its own inverse.
    function automatic logic [63:0] lane_map(input logic [63:0] p);
        return {byte_bitrev(p[63:32]), byte_bitrev(p[31:0])};
    endfunction

    function automatic logic [63:0] inv_pair(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, c, d;
        a = x ^ rotr(x, 25);
        b = y ^ rotr(y, 25);
        c = x ^ rotr(a, 31);
        d = y ^ rotr(b, 31);
        c = c ^ rotr(a, 20);
        d = d ^ rotr(b, 20);
        a = c ^ rotr(c, 31);
        b = d ^ rotr(d, 31);
        c = c ^ rotr(b, 26);
        d = d ^ rotr(a, 25);
        a = a ^ rotr(c, 17);
        b = b ^ rotr(d, 17);
        return {rotr(a, 16), rotr(b, 16)};
    endfunction

    function automatic logic [63:0] inv_slot_pair(input logic [63:0] slots);
        logic [63:0] lanes;
        lanes = lane_map(slots);
        return lane_map(inv_pair(lanes[63:32], lanes[31:0]));
    endfunction

    generate
        if (PAIRS_PER_CYCLE == 1) begin : g_shared
            logic [63:0] pair_sel;
            logic [63:0] pair_res;
            // PAIR1 works on the low pair; every other state presents the high pair.
            assign pair_sel  = (state == PAIR1) ? in_reg[63:0] : in_reg[127:64];
            assign pair_res  = inv_slot_pair(pair_sel);
            assign pair0_res = pair_res;
            assign pair1_res = pair_res;
        end else if (PAIRS_PER_CYCLE == 2) begin : g_dual
            assign pair0_res = inv_slot_pair(in_reg[127:64]);
            assign pair1_res = inv_slot_pair(in_reg[63:0]);
        end else begin : g_bad_param
            $error("lbox128_inv_iter: PAIRS_PER_CYCLE must be 1 or 2");
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        res_nxt   = out_data;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = PAIR0;
                end
            end
            PAIR0: begin
                res_nxt[127:64] = pair0_res;
                if (PAIRS_PER_CYCLE == 2) begin
                    res_nxt[63:0] = pair1_res;
                    state_nxt     = DONE;
                end else begin
                    state_nxt = PAIR1;
                end
            end
            PAIR1: begin
                res_nxt[63:0] = pair1_res;
                state_nxt     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_reg   <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            out_data <= res_nxt;
            if ((state == IDLE) && in_valid) begin
                in_reg <= in_data;
            end
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
